// File: rtl/clk_gate_pkg.sv
// Shared types and default timing constants for the idle-timeout clock-gate controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        CG_ACTIVE = 2'd0,
        CG_COUNT  = 2'd1,
        CG_GATED  = 2'd2,
        CG_WAKE   = 2'd3
    } cg_state_e;

    localparam int CgIdleCyclesDefault = 16;
    localparam int CgWakeCyclesDefault = 2;

endpackage

// File: rtl/clk_gate_ctrl_cnt.sv
// Load-zero / increment counter shared by the idle timeout and the wake hold-off.
// Latency: 1 cycle from control to count; no backpressure (clear has priority over increment).
module clk_gate_ctrl_cnt #(
    parameter int CntWidth = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    input  logic                i_inc,
    output logic [CntWidth-1:0] o_cnt
);

    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-timeout controller driving the clock-gate enable; runs on the free-running clock.
// Latency: all outputs registered, 1 cycle from input sample; four-phase wake handshake, no other flow control.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IdleCycles = CgIdleCyclesDefault,
    parameter int WakeCycles = CgWakeCyclesDefault,
    parameter int CntWidth   = $clog2(IdleCycles + WakeCycles + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                busy_i,
    input  logic                force_en_i,
    input  logic                wake_req_i,
    output logic                wake_ack_o,
    output logic                en_o,
    output logic                gated_o,
    output logic [CntWidth-1:0] idle_cnt_o
);

    localparam logic [CntWidth-1:0] IdleLast = CntWidth'(IdleCycles - 1);
    localparam logic [CntWidth-1:0] WakeLast = CntWidth'(WakeCycles - 1);

    cg_state_e           r_state;
    cg_state_e           w_state_nxt;
    logic                r_en;
    logic                r_gated;
    logic                r_ack;
    logic                w_act;
    logic                w_idle;
    logic                w_cnt_clr;
    logic                w_cnt_inc;
    logic [CntWidth-1:0] w_cnt;

    assign w_act  = busy_i | force_en_i;
    assign w_idle = !w_act && !wake_req_i;

    clk_gate_ctrl_cnt #(
        .CntWidth (CntWidth)
    ) u_cnt (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_cnt   (w_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b1;
        w_cnt_inc   = 1'b0;
        case (r_state)
            CG_ACTIVE: begin
                if (w_idle) begin
                    if (IdleCycles == 1) begin
                        w_state_nxt = CG_GATED;
                    end else begin
                        w_state_nxt = CG_COUNT;
                        w_cnt_clr   = 1'b0;
                        w_cnt_inc   = 1'b1;
                    end
                end
            end
            CG_COUNT: begin
                // Any non-idle sample, including one on the terminal count, cancels gating.
                if (!w_idle) begin
                    w_state_nxt = CG_ACTIVE;
                end else if (w_cnt == IdleLast) begin
                    w_state_nxt = CG_GATED;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_inc = 1'b1;
                end
            end
            CG_GATED: begin
                if (w_act || wake_req_i) begin
                    w_state_nxt = CG_WAKE;
                end
            end
            CG_WAKE: begin
                if (w_cnt == WakeLast) begin
                    w_state_nxt = CG_ACTIVE;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = CG_ACTIVE;
            end
        endcase
    end

    // Outputs are registered from the next state so en_o only moves just after the rising edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= CG_ACTIVE;
            r_en    <= 1'b1;
            r_gated <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_en    <= (w_state_nxt != CG_GATED);
            r_gated <= (w_state_nxt == CG_GATED);
            r_ack   <= wake_req_i && (r_ack || (r_state == CG_ACTIVE));
        end
    end

    assign en_o       = r_en;
    assign gated_o    = r_gated;
    assign wake_ack_o = r_ack;
    assign idle_cnt_o = w_cnt;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: dut0 with IdleCycles=4/WakeCycles=2, dut1 with IdleCycles=1.
module tb_clk_gate_ctrl;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic       force_en;
    logic       wake_req;
    logic       ack0, en0, gated0;
    logic [2:0] cnt0;
    logic       ack1, en1, gated1;
    logic [1:0] cnt1;

    int cyc;
    int n_checks;
    int n_fail;

    typedef struct {
        int    cyc;
        bit    dut;
        bit    en;
        bit    gated;
        bit    ack;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sb[$];

    clk_gate_ctrl #(.IdleCycles(4), .WakeCycles(2)) dut0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .busy_i     (busy),
        .force_en_i (force_en),
        .wake_req_i (wake_req),
        .wake_ack_o (ack0),
        .en_o       (en0),
        .gated_o    (gated0),
        .idle_cnt_o (cnt0)
    );

    clk_gate_ctrl #(.IdleCycles(1), .WakeCycles(2)) dut1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .busy_i     (busy),
        .force_en_i (force_en),
        .wake_req_i (wake_req),
        .wake_ack_o (ack1),
        .en_o       (en1),
        .gated_o    (gated1),
        .idle_cnt_o (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation whose target edge has just passed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       e;
            logic [5:0] act_v;
            logic [5:0] exp_v;
            e = sb.pop_front();
            exp_v = {e.en, e.gated, e.ack, 3'(e.cnt)};
            if (e.dut)
                act_v = {en1, gated1, ack1, 1'b0, cnt1};
            else
                act_v = {en0, gated0, ack0, cnt0};
            n_checks++;
            if (e.cyc != cyc || act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s dut%0d edge %0d: got en/gated/ack/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
                         e.nm, e.dut, e.cyc, act_v[5], act_v[4], act_v[3], act_v[2:0],
                         exp_v[5], exp_v[4], exp_v[3], exp_v[2:0]);
            end
        end
    end

    task automatic step(input bit r, input bit b, input bit f, input bit w, input bit d,
                        input bit e, input bit g, input bit a, input int c, input string nm);
        exp_t x;
        @(negedge clk);
        rst_n    = r;
        busy     = b;
        force_en = f;
        wake_req = w;
        x.cyc   = cyc + 1;
        x.dut   = d;
        x.en    = e;
        x.gated = g;
        x.ack   = a;
        x.cnt   = c;
        x.nm    = nm;
        sb.push_back(x);
    endtask

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        busy     = 1'b1;
        force_en = 1'b0;
        wake_req = 1'b0;

        // Reset held for three edges with busy asserted
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0, 0, 0, "reset");

        // Timeout: en_o falls on the 4th idle edge
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "timeout_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "timeout_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "timeout_c3");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "timeout_gate");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "gated_hold");

        // Wake request from GATED
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, "wake_w0");
        step(1, 0, 0, 1, 0, 1, 0, 0, 1, "wake_w1");
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, "wake_active");
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, "wake_ack_rise");
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, "wake_ack_hold");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "wake_ack_drop");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "resume_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "resume_c3");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "resume_gate");

        // force_en from GATED, held for 20 edges
        step(1, 0, 1, 0, 0, 1, 0, 0, 0, "force_w0");
        step(1, 0, 1, 0, 0, 1, 0, 0, 1, "force_w1");
        for (int i = 0; i < 18; i++) step(1, 0, 1, 0, 0, 1, 0, 0, 0, "force_hold");

        // Restart: one busy sample inside the count
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "restart_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "restart_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "restart_c3");
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, "restart_busy");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "restart_n1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "restart_n2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "restart_n3");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "restart_gate");

        // busy wakes, busy ignored inside WAKE
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, "busy_w0");
        step(1, 1, 0, 0, 0, 1, 0, 0, 1, "busy_w1");
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, "busy_active");

        // Wake request on the terminal count edge beats gating
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "race_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "race_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "race_c3");
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, "race_wake_wins");
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, "race_ack");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "race_drop");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "race_c2b");

        // Reset mid-count
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_in_count");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "post_rst_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "post_rst_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "post_rst_c3");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "post_rst_gate");

        // Activity and reset on the same edge in GATED: reset wins
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, "rst_vs_act");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "rst_vs_act_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "rst_vs_act_c2");
        step(1, 0, 0, 0, 0, 1, 0, 0, 3, "rst_vs_act_c3");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, "rst_vs_act_gate");

        // Reset inside WAKE
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, "wake_pre_rst");
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, "rst_in_wake");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "post_wake_rst_c1");
        step(1, 0, 0, 0, 0, 1, 0, 0, 2, "post_wake_rst_c2");

        // Reset clears an active acknowledge
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, "ack_pre");
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, "ack_up");
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, "rst_clears_ack");
        step(1, 0, 0, 1, 0, 1, 0, 1, 0, "ack_after_rst");
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, "ack_release");

        // IdleCycles=1 corner on dut1
        step(0, 1, 0, 0, 1, 1, 0, 0, 0, "i1_reset");
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, "i1_first_idle_gates");
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, "i1_gated_hold");
        step(1, 1, 0, 0, 1, 1, 0, 0, 0, "i1_w0");
        step(1, 0, 0, 0, 1, 1, 0, 0, 1, "i1_w1");
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, "i1_active");
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, "i1_regate");
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, "i1_wake_req");
        step(0, 0, 0, 1, 1, 1, 0, 0, 0, "i1_rst_in_wake");
        step(1, 0, 0, 0, 1, 0, 1, 0, 0, "i1_post_rst_gate");

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
